// File: rtl/wb_melody_pkg.sv
// wb_melody_pkg: register map, FSM states and FIFO entry width for wb_melody_seq
package wb_melody_pkg;
  localparam logic [7:0] ADR_FREQ   = 8'h00;
  localparam logic [7:0] ADR_PUSH   = 8'h04;
  localparam logic [7:0] ADR_CTRL   = 8'h08;
  localparam logic [7:0] ADR_STATUS = 8'h0C;
  localparam int ENTRY_W = 48;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, PLAY} state_t;
endpackage

// File: rtl/melody_fifo.sv
// melody_fifo: synchronous FIFO with push/pop/flush and occupancy count
module melody_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign dout = mem[rd];
  always_ff @(posedge clk) if (push_ok) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + AW'(1);
      if (pop_ok) rd <= rd + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/wb_melody_seq.sv
// wb_melody_seq: Wishbone note sequencer driving a tone generator from a (freq, duration) FIFO
// Define WAIT_DONE_EN to hold each note until tone_done_i before its duration starts.
module wb_melody_seq
  import wb_melody_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wb_stb_i,
  input  logic wb_cyc_i,
  output logic wb_ack_o,
  input  logic wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0] wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic [31:0] freq_o,
  output logic stop_o,
  input  logic tone_done_i
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state, next;
  logic ack_r, acc, wr, push, pop, flush, ctrl_wr, stat_wr;
  logic run, ovf, full, empty, wrap, last;
  logic [7:0] adr;
  logic [31:0] freq_stage, rdata;
  logic [ENTRY_W-1:0] entry, head;
  logic [15:0] dur;
  logic [PW-1:0] presc;
  logic [$clog2(DEPTH):0] count;
  logic unused;
  assign unused = &{1'b0, wb_sel_i, wb_adr_i[31:8]
`ifndef WAIT_DONE_EN
    , tone_done_i
`endif
  };
  assign adr = wb_adr_i[7:0];
  assign acc = wb_stb_i & wb_cyc_i & ~ack_r;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_r;
  assign wr = acc & wb_we_i;
  assign push = wr && adr == ADR_PUSH;
  assign ctrl_wr = wr && adr == ADR_CTRL;
  assign stat_wr = wr && adr == ADR_STATUS;
  assign flush = ctrl_wr & wb_dat_i[1];
  assign wrap = presc == PW'(TICK_DIV - 1);
  assign last = dur == 16'd0 || (wrap && dur == 16'd1);
  melody_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .din({freq_stage, wb_dat_i[15:0]}), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    rdata = adr == ADR_CTRL ? {31'b0, run} :
            adr == ADR_STATUS ? {16'b0, 8'(count), 4'b0, ovf, full, empty, state != IDLE} : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r <= 1'b0;
      wb_dat_o <= '0;
      freq_stage <= '0;
      run <= 1'b0;
      ovf <= 1'b0;
    end else begin
      ack_r <= acc;
      if (acc) wb_dat_o <= rdata;
      if (wr && adr == ADR_FREQ) freq_stage <= wb_dat_i;
      if (ctrl_wr) run <= wb_dat_i[0];
      if (push && full) ovf <= 1'b1;
      else if (stat_wr && wb_dat_i[3]) ovf <= 1'b0;
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    pop = 1'b0;
    if (!run) next = IDLE;
    else begin
      unique case (state)
        IDLE: if (!empty) begin
          pop = 1'b1;
          next = LOAD;
        end
`ifdef WAIT_DONE_EN
        LOAD: next = WAIT;
        WAIT: if (tone_done_i) next = PLAY;
`else
        LOAD: next = PLAY;
`endif
        PLAY: if (last) begin
          pop = !empty;
          next = empty ? IDLE : LOAD;
        end
        default: next = IDLE;
      endcase
    end
  end
  // The popped entry is latched so LOAD sees it after the FIFO head has advanced.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
      freq_o <= '0;
      stop_o <= 1'b1;
      dur <= '0;
      presc <= '0;
    end else begin
      if (pop) entry <= head;
      if (next == IDLE) stop_o <= 1'b1;
      else if (state == LOAD) begin
        freq_o <= entry[47:16];
        stop_o <= entry[47:16] == 32'd0;
        dur <= entry[15:0];
        presc <= '0;
      end else if (state == PLAY) begin
        presc <= wrap ? '0 : presc + PW'(1);
        if (wrap) dur <= dur - 16'd1;
      end
    end
  end
endmodule
